weight_loader: RTL
==================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter numWeight, default 784: weight words per neuron memory; must be at least 2.
REQ-002 Parameter neuronNo, default 5: neuron index this loader serves.
REQ-003 Parameter layerNo, default 1: layer index this loader serves.
REQ-004 Parameter addressWidth, default 10: memory address width; 2^addressWidth >= numWeight.
REQ-005 Parameter dataWidth, default 16: weight word width.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 reload  input  1  one-cycle pulse; restarts loading for this neuron.
REQ-009 stall  input  1  backpressure from the downstream side; blocks acceptance.
REQ-010 s_valid  input  1  weight beat valid.
REQ-011 s_data  input  dataWidth  weight value.
REQ-012 cfg_layer  input  32  layer tag of the current beat.
REQ-013 cfg_neuron  input  32  neuron tag of the current beat.
REQ-014 s_ready  output  1  beat can be taken this cycle.
REQ-015 wen  output  1  memory write enable.
REQ-016 wadd  output  addressWidth  memory write address.
REQ-017 win  output  dataWidth  memory write data.
REQ-018 load_done  output  1  all numWeight words written.
REQ-019 overflow  output  1  sticky flag: extra matching beat received after done.
REQ-020 checksum  output  dataWidth  running sum of written words (see REQ-036).

Function
REQ-021 s_ready shall be combinational: !stall && !reload && !rst.
REQ-022 A beat shall be taken when s_valid && s_ready; it shall match only when cfg_layer==layerNo && cfg_neuron==neuronNo.
REQ-023 Non-matching taken beats shall be consumed without effect, with no write and no state change.
REQ-024 FSM states: IDLE, LOAD, DONE; reset state is IDLE.
REQ-025 IDLE->LOAD on the first matching beat; that beat writes address 0.
REQ-026 In LOAD, each matching beat writes the next address; the address counter increments by 1 per write.
REQ-027 On the write to address numWeight-1, go LOAD->DONE; the counter returns to 0 and does not wrap past numWeight-1.
REQ-028 Write latency: wen, wadd and win shall be registered and appear exactly 1 cycle after the accepting edge.
REQ-029 wen shall be high for one cycle per matching beat; wadd and win hold their last values when wen is low.
REQ-030 load_done shall be registered, rising in the same cycle as wen for address numWeight-1, and staying high in DONE.
REQ-031 In DONE, matching beats shall still be consumed, with no write, and shall set overflow; overflow stays set until reset or reload.
REQ-032 reload shall force IDLE from any state: counter to 0, load_done and overflow to 0, pending wen to 0; a beat in the same cycle is not taken.
REQ-033 Back-to-back matching beats shall be written at full rate, one per cycle; stall gaps shall not lose or duplicate addresses.

Reset
REQ-034 On a rst edge, all state shall reset regardless of other inputs: state IDLE, counter 0, wen 0, wadd 0, win 0, load_done 0, overflow 0, checksum 0.
REQ-035 A rst mid-LOAD shall discard progress; the next matching beat writes address 0.

Configuration
REQ-036 With macro WLOAD_CHECKSUM_EN defined, checksum shall add each written word modulo 2^dataWidth, updating with wen, and clear on rst or reload.
REQ-037 Without WLOAD_CHECKSUM_EN, checksum shall be constant 0 and no adder shall exist; all other behaviour is identical.

Verification (numWeight=3, dataWidth=16, layerNo=1, neuronNo=5)
REQ-038 Stimulus: 3 matching beats 0x0001, 0x0002, 0x0003 back-to-back.
  Response: wen on 3 consecutive cycles, wadd 0,1,2, win matching; load_done rises with wadd=2; checksum=0x0006 if enabled, else 0.
REQ-039 Stimulus: beats tagged neuron 4 interleaved with matching beats.
  Response: s_ready=1 for all beats; writes occur only for matching beats, with contiguous addresses 0,1,2.
REQ-040 Stimulus: stall=1 for 2 cycles mid-load with s_valid held.
  Response: s_ready=0 during the stall; no write; resume writes at the next address.
REQ-041 Stimulus: 4th matching beat 0xFFFF after done.
  Response: no wen; overflow=1; checksum unchanged.
REQ-042 Stimulus: reload together with a valid matching beat while in LOAD at address 1.
  Response: beat not taken; load_done=0; the next beat writes address 0.
REQ-043 Stimulus: rst asserted after 2 writes.
  Response: all outputs 0 the next cycle; reload sequence 0xAAAA, 0xBBBB, 0xCCCC gives wadd 0,1,2; checksum=0x3331 when enabled.

Source files
------------

// File: rtl/weight_loader.sv
// Streams tagged weight beats into one neuron's weight memory, writing each matching beat to the next address.
// Optional running checksum of written words is enabled by defining WLOAD_CHECKSUM_EN.
module weight_loader #(
  parameter int numWeight    = 784,
  parameter int neuronNo     = 5,
  parameter int layerNo      = 1,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reload,
  input  logic                    stall,
  input  logic                    s_valid,
  input  logic [dataWidth-1:0]    s_data,
  input  logic [31:0]             cfg_layer,
  input  logic [31:0]             cfg_neuron,
  output logic                    s_ready,
  output logic                    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    load_done,
  output logic                    overflow,
  output logic [dataWidth-1:0]    checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(numWeight - 1);

  state_t                  state, state_next;
  logic [addressWidth-1:0] cnt, cnt_next;
  logic                    hit, write, last, ovf_set;

  assign s_ready = !stall && !reload && !rst;
  assign hit     = s_valid && s_ready &&
                   (cfg_layer == 32'(layerNo)) && (cfg_neuron == 32'(neuronNo));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    write      = 1'b0;
    last       = 1'b0;
    ovf_set    = 1'b0;
    if (hit) begin
      unique case (state)
        IDLE: begin
          write      = 1'b1;
          cnt_next   = addressWidth'(1);
          state_next = LOAD;
        end
        LOAD: begin
          write = 1'b1;
          if (cnt == LastAddr) begin
            last       = 1'b1;
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        DONE:    ovf_set = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wen       <= 1'b0;
      wadd      <= '0;
      win       <= '0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (reload) begin
      // wadd/win keep their last values; only the load progress is cleared
      state     <= IDLE;
      cnt       <= '0;
      wen       <= 1'b0;
      load_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      wen   <= write;
      if (write) begin
        wadd <= cnt;
        win  <= s_data;
      end
      if (last)    load_done <= 1'b1;
      if (ovf_set) overflow  <= 1'b1;
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || reload) checksum <= '0;
    else if (write)    checksum <= checksum + s_data;
  end
`else
  assign checksum = '0;
`endif

endmodule
